// File: rtl/decision_pkg.sv
// Shared types for the decision block input path: debouncer state encoding
// and the decision code width/type.
package decision_pkg;

  typedef enum logic [1:0] {
    UNINIT   = 2'd0,
    SETTLING = 2'd1,
    STABLE   = 2'd2
  } deb_state_e;

  localparam int DECISION_WIDTH = 4;

  typedef logic [DECISION_WIDTH-1:0] decision_code_t;

endpackage

// File: rtl/decision_input_debouncer_sync_chain.sv
// Multi-flop synchroniser for a vector of asynchronous inputs.
// All stages clear to zero on reset.
module sync_chain #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_reg [STAGES];

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) stage_reg[gi] <= '0;
          else        stage_reg[gi] <= d;
        end
      end else begin : g_next
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) stage_reg[gi] <= '0;
          else        stage_reg[gi] <= stage_reg[gi-1];
        end
      end
    end
  endgenerate

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/decision_input_debouncer.sv
// Synchronises and debounces raw inputs into a settled code for the decision block.
// Optional change_count output enabled by DECISION_DEBOUNCE_EVENT_COUNT_EN.
module decision_input_debouncer
  import decision_pkg::*;
#(
  parameter int WIDTH           = DECISION_WIDTH,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             sample_en,
  output logic [WIDTH-1:0] code_out,
  output logic             code_valid,
`ifdef DECISION_DEBOUNCE_EVENT_COUNT_EN
  output logic             code_changed,
  output logic [7:0]       change_count
`else
  output logic             code_changed
`endif
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q;

  sync_chain #(
    .WIDTH (WIDTH),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (raw_in),
    .q    (sync_q)
  );

  deb_state_e       state_reg,   state_next;
  logic [WIDTH-1:0] cand_reg,    cand_next;
  logic [CNT_W-1:0] cnt_reg,     cnt_next;
  logic [WIDTH-1:0] code_reg,    code_next;
  logic             valid_reg,   valid_next;
  logic             changed_reg, changed_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= UNINIT;
      cand_reg    <= '0;
      cnt_reg     <= '0;
      code_reg    <= '0;
      valid_reg   <= 1'b0;
      changed_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cand_reg    <= cand_next;
      cnt_reg     <= cnt_next;
      code_reg    <= code_next;
      valid_reg   <= valid_next;
      changed_reg <= changed_next;
    end
  end

  // A mismatch restarts the candidate before any acceptance is considered.
  always_comb begin
    state_next   = state_reg;
    cand_next    = cand_reg;
    cnt_next     = cnt_reg;
    code_next    = code_reg;
    valid_next   = valid_reg;
    changed_next = 1'b0;
    if (sync_q != cand_reg) begin
      cand_next = sync_q;
      cnt_next  = '0;
      if (state_reg != UNINIT) state_next = SETTLING;
    end else if (sample_en && (cnt_reg < CNT_LAST)) begin
      cnt_next = cnt_reg + 1'b1;
    end else if ((cnt_reg == CNT_LAST) && (state_reg != STABLE)) begin
      code_next    = cand_reg;
      state_next   = STABLE;
      valid_next   = 1'b1;
      // Re-accepting the code already on the output after a bounce is silent.
      changed_next = !valid_reg || (cand_reg != code_reg);
    end
  end

  assign code_out     = code_reg;
  assign code_valid   = valid_reg;
  assign code_changed = changed_reg;

`ifdef DECISION_DEBOUNCE_EVENT_COUNT_EN
  logic [7:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                count_reg <= '0;
    else if (changed_next && count_reg != 8'hFF) count_reg <= count_reg + 8'd1;
  end

  assign change_count = count_reg;
`endif

endmodule

// File: tb/tb_decision_input_debouncer.sv
// Directed self-checking bench for decision_input_debouncer (default parameters).
// Honors DECISION_DEBOUNCE_EVENT_COUNT_EN for the change_count checks.
module tb_decision_input_debouncer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] raw_in;
  logic       sample_en;
  logic [3:0] code_out;
  logic       code_valid;
  logic       code_changed;
`ifdef DECISION_DEBOUNCE_EVENT_COUNT_EN
  logic [7:0] change_count;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int pulses       = 0;
  int accept_at;

  always #5 clk = ~clk;

  decision_input_debouncer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .raw_in      (raw_in),
    .sample_en   (sample_en),
    .code_out    (code_out),
    .code_valid  (code_valid),
`ifdef DECISION_DEBOUNCE_EVENT_COUNT_EN
    .code_changed(code_changed),
    .change_count(change_count)
`else
    .code_changed(code_changed)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (code_changed) pulses++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    raw_in    = 4'b0000;
    sample_en = 1'b1;
    #12;
    check("reset_code_out", 32'(code_out), 32'h0);
    check("reset_valid", 32'(code_valid), 32'h0);
    check("reset_changed", 32'(code_changed), 32'h0);

    // 1: first acceptance after release; chain and candidate already match 0000,
    // so only the 15-step counter run-up plus the accept edge is needed.
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    ticks(15);
    check("init_valid_e15", 32'(code_valid), 32'h0);
    tick();
    check("init_valid_e16", 32'(code_valid), 32'h1);
    check("init_changed_e16", 32'(code_changed), 32'h1);
    check("init_code", 32'(code_out), 32'h0);
    tick();
    check("init_changed_e17", 32'(code_changed), 32'h0);
    check("init_pulses", 32'(pulses), 32'd1);
`ifdef DECISION_DEBOUNCE_EVENT_COUNT_EN
    check("init_count", 32'(change_count), 32'd1);
`endif
    ticks(5);

    // 2: 0000 -> 0101 lands exactly on edge 19.
    raw_in = 4'b0101;
    pulses = 0;
    ticks(18);
    check("lat_code_e18", 32'(code_out), 32'h0);
    check("lat_pulses_e18", 32'(pulses), 32'd0);
    tick();
    check("lat_code_e19", 32'(code_out), 32'h5);
    check("lat_changed_e19", 32'(code_changed), 32'h1);
    tick();
    check("lat_changed_e20", 32'(code_changed), 32'h0);
    check("lat_pulses", 32'(pulses), 32'd1);

    // 3: bounce to 1111 for 10 cycles then back; silently re-accepted.
    pulses = 0;
    raw_in = 4'b1111;
    ticks(10);
    raw_in = 4'b0101;
    ticks(40);
    check("bounce_code", 32'(code_out), 32'h5);
    check("bounce_pulses", 32'(pulses), 32'd0);
    check("bounce_valid", 32'(code_valid), 32'h1);

    // 4: 0101 -> 1010 with sample_en every 4th cycle. Candidate loads at i=2,
    // enabled ticks at i=4,8,...,60 bring cnt to 15, accept at i=61.
    pulses    = 0;
    accept_at = -1;
    raw_in    = 4'b1010;
    for (int i = 0; i < 200; i++) begin
      sample_en = (i % 4 == 0);
      tick();
      if (accept_at < 0 && code_out == 4'b1010) accept_at = i;
    end
    sample_en = 1'b1;
    check("slow_accept_cycle", 32'(accept_at), 32'd61);
    check("slow_code", 32'(code_out), 32'hA);
    check("slow_pulses", 32'(pulses), 32'd1);

    // 5: reset 8 cycles into settling toward 0011, then full debounce again.
    raw_in = 4'b0011;
    ticks(8);
    rst_n = 1'b0;
    #1;
    check("abort_code", 32'(code_out), 32'h0);
    check("abort_valid", 32'(code_valid), 32'h0);
    check("abort_changed", 32'(code_changed), 32'h0);
    ticks(3);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    ticks(18);
    check("rerun_valid_e18", 32'(code_valid), 32'h0);
    tick();
    check("rerun_valid_e19", 32'(code_valid), 32'h1);
    check("rerun_code_e19", 32'(code_out), 32'h3);
    check("rerun_changed_e19", 32'(code_changed), 32'h1);

    // 6: sweep every code from a clean reset.
    @(negedge clk);
    rst_n = 1'b0;
    raw_in = 4'b0000;
    #2;
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int v = 0; v < 16; v++) begin
      raw_in = 4'(v);
      ticks(40);
      check($sformatf("sweep_code_%0d", v), 32'(code_out), 32'(v));
    end
    check("sweep_pulses", 32'(pulses), 32'd16);
`ifdef DECISION_DEBOUNCE_EVENT_COUNT_EN
    check("sweep_count", 32'(change_count), 32'd16);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
